cisr_encoder: RTL and testbench
===============================

Name: cisr_encoder

Overview:
- Producer-side scheduler for the Compressed Interleaved Sparse Row (CISR) format; the decoder consumes what this block emits.
- Accepts a sequential stream of row lengths (row 0, 1, 2, ...) and assigns each row to one of NUM_CH interleaved channels.
- Each channel emits one nonzero slot per cycle until its current row is exhausted, then takes the next row.
- Per-channel row-length announcements drive the downstream CISR decoder and the value/column streamers.

Parameters:
- NUM_CH, 4, number of interleaved channels.
- LEN_W, 5, row-length width in bits; a row holds at most 2^LEN_W-1 nonzeros.
- ID_W, 5, row-ID width in bits; row IDs wrap modulo 2^ID_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rowLengthIn  in  LEN_W  length of the next row.
- rowValid  in  1  rowLengthIn is valid.
- rowLast  in  1  the row offered is the final row of the matrix; qualified by rowValid.
- rowReady  out  1  a row is accepted at this edge when rowValid && rowReady.
- lenOut  out  NUM_CH*LEN_W  per-channel length of the newly assigned row; channel k occupies bits [k*LEN_W +: LEN_W].
- lenValid  out  NUM_CH  per-channel 1-cycle pulse; lenOut[k] is valid.
- rowIdOut  out  NUM_CH*ID_W  per-channel ID of the row currently or most recently assigned.
- slotValid  out  NUM_CH  channel k emits one nonzero element this cycle.
- done  out  1  1-cycle pulse: last row accepted and all channels drained.

Behaviour:
- State per channel:
  - rem[k] (LEN_W): slots remaining.
  - rowId[k] (ID_W).
  - lenReg[k].
- Global state:
  - nextId counter (ID_W).
  - lastSeen flag.
  - donePending flag.
- Reset:
  - rem, rowId, lenReg, nextId, lastSeen all 0.
  - Outputs lenValid=0, slotValid=0, done=0, lenOut=0, rowIdOut=0.
  - Reset wins over any simultaneous handshake.
- Free channel: rem[k]==0.
- rowReady (combinational from state):
  - high when any channel is free and lastSeen==0.
  - After the last row is accepted, rowReady stays 0 until reset or done.
- Accept rule:
  - At most one row is accepted per edge.
  - It goes to the lowest-index free channel k*.
  - At the accepting edge: rem[k*]<=rowLengthIn, rowId[k*]<=nextId, lenReg[k*]<=rowLengthIn, nextId<=nextId+1 (wraps at 2^ID_W).
  - lenValid[k*] is high for exactly the following cycle. All other lenValid bits are 0.
- Slot emission:
  - slotValid[k] = (rem[k]!=0), combinational from state.
  - Every edge where rem[k]!=0: rem[k]<=rem[k]-1.
  - Latency: a row accepted at edge e produces slotValid in the len cycles immediately after e, aligned with the lenValid pulse.
- Channel reuse: a channel whose rem reaches 0 at edge e is free in the cycle after e. It may accept a new row at edge e+1, so there is no bubble beyond one cycle.
- Zero-length rows:
  - Accepted and assigned normally; lenValid pulses with lenOut=0, and the row ID is consumed.
  - slotValid stays 0.
  - The channel is free again in the very next cycle.
- rowLast:
  - Sampled only on an accepting edge; sets lastSeen.
- done:
  - Asserted for exactly 1 cycle in the first cycle where lastSeen==1 and all rem==0.
  - At that edge, lastSeen clears and nextId resets to 0, ready for the next matrix.
- Undefined input: rowValid high while rowReady low is not a transfer; the row must be held by the source.
- Mid-operation reset: all in-flight rows are discarded, with no done pulse.

Decomposition:
- Shared package cisr_pkg:
  - NUM_CH, LEN_W, ID_W defaults.
  - Lane-slice helper constants, also used by the CISR decoder.
- Sub-module cisr_channel:
  - Holds rem, rowId, lenReg for one lane.
  - Inputs: load, len, id.
  - Outputs: free, slotValid, lenValid.
  - Instantiated NUM_CH times.
- The top level holds the priority picker, nextId, lastSeen and done logic.

Test Plan:
- Reset for 10 cycles, then rows 3,2,4,1 offered back-to-back (last on 1):
  - Accepted at edges e0..e3 to ch0..ch3 with IDs 0..3.
  - slotValid counts 3,2,4,1.
  - ch0 and ch1 are free after e3; ch2 drains after e6; done pulses once in the cycle after e6.
- Same stream plus row 5 (len 2, last) offered at e4: assigned to ch0 (lowest free index over ch1), ID 4, lenValid[0] pulse with lenOut=2.
- Rows 0,0,2 with last: first two rows both go to ch0 with lenValid pulses and lenOut=0; row 2 also goes to ch0 with ID 2; done follows 2 slots later.
- All four channels loaded with length 31 and a 5th row held valid:
  - rowReady stays 0 for 28 cycles.
  - The held row is accepted on the edge after the first channel reaches rem=0, and its value and ID are unchanged.
- 33 rows of length 1 with no last: rowIdOut wraps 31 to 0; slotValid never exceeds one cycle per row.
- Reset asserted while ch2 has rem=3: the next cycle has all outputs 0, no done, and nextId=0.

Source files
------------

// File: rtl/cisr_pkg.sv
// Shared constants for the CISR encoder/decoder pair.
// Lane-slice helpers locate a channel's field in packed buses.
package cisr_pkg;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 5;
  localparam int ID_W   = 5;

  function automatic int lane_lo(int k, int w);
    return k * w;
  endfunction

  function automatic int bus_w(int n, int w);
    return n * w;
  endfunction
endpackage

// File: rtl/cisr_channel.sv
// One interleaved CISR lane: counts down the slots of its
// current row and announces each newly assigned row for a cycle.
module cisr_channel
  import cisr_pkg::*;
#(
  parameter int LW = LEN_W,
  parameter int IW = ID_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [LW-1:0] len_i,
  input  logic [IW-1:0] id_i,
  output logic          free_o,
  output logic          slotValid_o,
  output logic          lenValid_o,
  output logic [LW-1:0] len_o,
  output logic [IW-1:0] id_o
);

  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] id_q, id_d;
  logic          lenValid_q;

  always_comb begin
    rem_d = rem_q;
    len_d = len_q;
    id_d  = id_q;
    if (load_i) begin
      rem_d = len_i;
      len_d = len_i;
      id_d  = id_i;
    end else if (rem_q != '0) begin
      rem_d = rem_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      len_q      <= '0;
      id_q       <= '0;
      lenValid_q <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      len_q      <= len_d;
      id_q       <= id_d;
      lenValid_q <= load_i;
    end
  end

  assign free_o      = (rem_q == '0);
  assign slotValid_o = (rem_q != '0);
  assign lenValid_o  = lenValid_q;
  assign len_o       = len_q;
  assign id_o        = id_q;

endmodule

// File: rtl/cisr_encoder.sv
// CISR producer: hands incoming rows to the lowest free lane,
// numbers them, and signals done once the last row drains.
module cisr_encoder
  import cisr_pkg::*;
#(
  parameter int NCH = NUM_CH,
  parameter int LW  = LEN_W,
  parameter int IW  = ID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LW-1:0]     rowLengthIn,
  input  logic              rowValid,
  input  logic              rowLast,
  output logic              rowReady,
  output logic [NCH*LW-1:0] lenOut,
  output logic [NCH-1:0]    lenValid,
  output logic [NCH*IW-1:0] rowIdOut,
  output logic [NCH-1:0]    slotValid,
  output logic              done
);

  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic [IW-1:0]  nextId_q, nextId_d;
  logic           lastSeen_q, lastSeen_d;
  logic           accept;
  logic           found;

  assign rowReady = (|free) && !lastSeen_q;
  assign accept   = rowValid && rowReady;
  assign done     = lastSeen_q && (&free);

  // Lowest-index free lane wins.
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (free[k] && !found) begin
        load[k] = accept;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    nextId_d   = nextId_q;
    lastSeen_d = lastSeen_q;
    if (done) begin
      nextId_d   = '0;
      lastSeen_d = 1'b0;
    end else if (accept) begin
      nextId_d = nextId_q + IW'(1);
      if (rowLast) lastSeen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nextId_q   <= '0;
      lastSeen_q <= 1'b0;
    end else begin
      nextId_q   <= nextId_d;
      lastSeen_q <= lastSeen_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    cisr_channel #(
      .LW(LW),
      .IW(IW)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load[k]),
      .len_i      (rowLengthIn),
      .id_i       (nextId_q),
      .free_o     (free[k]),
      .slotValid_o(slotValid[k]),
      .lenValid_o (lenValid[k]),
      .len_o      (lenOut[lane_lo(k, LW) +: LW]),
      .id_o       (rowIdOut[lane_lo(k, IW) +: IW])
    );
  end

endmodule

// File: tb/tb_cisr_encoder.sv
// Bench for cisr_encoder: directed scenarios then random rows,
// compared each cycle against an interval-based row model.
module tb_cisr_encoder;
  localparam int NCH = 4;
  localparam int LW  = 5;
  localparam int IW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [LW-1:0]     rowLengthIn;
  logic              rowValid;
  logic              rowLast;
  logic              rowReady;
  logic [NCH*LW-1:0] lenOut;
  logic [NCH-1:0]    lenValid;
  logic [NCH*IW-1:0] rowIdOut;
  logic [NCH-1:0]    slotValid;
  logic              done;

  always #5 clk = ~clk;

  cisr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .rowLengthIn(rowLengthIn),
    .rowValid   (rowValid),
    .rowLast    (rowLast),
    .rowReady   (rowReady),
    .lenOut     (lenOut),
    .lenValid   (lenValid),
    .rowIdOut   (rowIdOut),
    .slotValid  (slotValid),
    .done       (done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Each lane remembers its row as a cycle interval:
  // announced in asgCyc, slots through busyEnd inclusive.
  int          c = 0;
  int          busyEnd[NCH];
  int          asgCyc[NCH];
  logic [LW-1:0] mLen[NCH];
  logic [IW-1:0] mId[NCH];
  int          nextId;
  bit          lastSeen;
  bit          mAcc;

  function automatic bit m_free(int k);
    return c > busyEnd[k];
  endfunction

  function automatic bit m_ready();
    bit any = 1'b0;
    for (int k = 0; k < NCH; k++) any |= m_free(k);
    return any && !lastSeen;
  endfunction

  function automatic bit m_done();
    bit all = 1'b1;
    for (int k = 0; k < NCH; k++) all &= m_free(k);
    return lastSeen && all;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      busyEnd[k] = -1;
      asgCyc[k]  = -1;
      mLen[k]    = '0;
      mId[k]     = '0;
    end
    nextId   = 0;
    lastSeen = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: got %0h want %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0]    eSlot, eLv;
    logic [NCH*LW-1:0] eLen;
    logic [NCH*IW-1:0] eId;
    for (int k = 0; k < NCH; k++) begin
      eSlot[k] = (c <= busyEnd[k]);
      eLv[k]   = (asgCyc[k] == c);
      eLen[k*LW +: LW] = mLen[k];
      eId[k*IW +: IW]  = mId[k];
    end
    chk("rowReady",  32'(rowReady),  32'(m_ready()));
    chk("done",      32'(done),      32'(m_done()));
    chk("slotValid", 32'(slotValid), 32'(eSlot));
    chk("lenValid",  32'(lenValid),  32'(eLv));
    chk("lenOut",    32'(lenOut),    32'(eLen));
    chk("rowIdOut",  32'(rowIdOut),  32'(eId));
  endtask

  task automatic model_edge(bit v, int len, bit last, bit rst);
    bit got = 1'b0;
    mAcc = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_done()) begin
      lastSeen = 1'b0;
      nextId   = 0;
    end else if (v && m_ready()) begin
      for (int k = 0; k < NCH; k++) begin
        if (!got && m_free(k)) begin
          got       = 1'b1;
          busyEnd[k] = c + len;
          asgCyc[k]  = c + 1;
          mLen[k]    = LW'(len);
          mId[k]     = IW'(nextId);
        end
      end
      nextId = (nextId + 1) % (1 << IW);
      if (last) lastSeen = 1'b1;
      mAcc = 1'b1;
    end
    c++;
  endtask

  task automatic step(bit v, int len, bit last, bit rst);
    rowValid    = v;
    rowLengthIn = LW'(len);
    rowLast     = last;
    reset       = rst;
    check_outputs();
    @(posedge clk);
    model_edge(v, len, last, rst);
    #1;
  endtask

  int  guard;
  bit  pv;
  int  pl;
  bit  plast;
  bit  prst;

  initial begin
    reset       = 1'b1;
    rowValid    = 1'b0;
    rowLengthIn = '0;
    rowLast     = 1'b0;
    model_reset();
    @(posedge clk);
    c = 1;
    #1;
    repeat (9) step(0, 0, 0, 1);

    // rows 3,2,4,1 back-to-back, last on the 1
    step(1, 3, 0, 0);
    step(1, 2, 0, 0);
    step(1, 4, 0, 0);
    step(1, 1, 1, 0);
    repeat (6) step(0, 0, 0, 0);

    // same stream plus a fifth row of length 2
    step(1, 3, 0, 0);
    step(1, 2, 0, 0);
    step(1, 4, 0, 0);
    step(1, 1, 0, 0);
    step(1, 2, 1, 0);
    repeat (8) step(0, 0, 0, 0);

    // zero-length rows reuse lane 0 immediately
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 2, 1, 0);
    repeat (5) step(0, 0, 0, 0);

    // all lanes full, fifth row held until a lane frees
    repeat (4) step(1, 31, 0, 0);
    guard = 0;
    do begin
      step(1, 7, 1, 0);
      guard++;
    end while (!mAcc && guard < 40);
    repeat (40) step(0, 0, 0, 0);

    // 33 single-slot rows, row ID wraps
    repeat (33) step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // reset while lane 2 still has 3 slots left
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 2, 1, 0);
    repeat (4) step(0, 0, 0, 0);

    // random rows, held by the source until accepted
    pv = 1'b0;
    pl = 0;
    plast = 1'b0;
    repeat (600) begin
      if (!pv && ($urandom % 4 != 0)) begin
        pv    = 1'b1;
        pl    = ($urandom % 3 == 0) ? int'($urandom % 32)
                                    : int'($urandom % 5);
        plast = ($urandom % 20 == 0);
      end
      prst = ($urandom % 200 == 0);
      step(pv, pv ? pl : 0, pv && plast, prst);
      if (mAcc) pv = 1'b0;
    end
    repeat (40) step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
